// File: rtl/reg_file_scoreboard_pkg.sv
// Shared defaults and helpers for the register file with pending-write scoreboard.
package reg_file_scoreboard_pkg;
    localparam int RF_XLEN   = 32;
    localparam int RF_NREGS  = 32;
    localparam int RF_NRD    = 2;
    localparam int RF_BYPASS = 1;

    function automatic int rf_aw(input int nregs);
        return $clog2(nregs);
    endfunction
endpackage

// File: rtl/reg_file_scoreboard_if.sv
// Decode/writeback bus of the register file; slave is the register file side.
interface reg_file_scoreboard_if
    import reg_file_scoreboard_pkg::*;
#(
    parameter int XLEN  = RF_XLEN,
    parameter int NREGS = RF_NREGS,
    parameter int NRD   = RF_NRD
);
    localparam int AW = rf_aw(NREGS);

    logic [NRD*AW-1:0]   i_Rnum;
    logic [NRD*XLEN-1:0] o_Rd;
    logic [NRD-1:0]      o_Rbusy;
    logic                o_Hazard;
    logic                i_Iss_en;
    logic [AW-1:0]       i_Iss_num;
    logic                o_Iss_ready;
    logic                i_Wen;
    logic [AW-1:0]       i_Wnum;
    logic [XLEN-1:0]     i_Wd;

    modport master (
        output i_Rnum, i_Iss_en, i_Iss_num, i_Wen, i_Wnum, i_Wd,
        input  o_Rd, o_Rbusy, o_Hazard, o_Iss_ready
    );

    modport slave (
        input  i_Rnum, i_Iss_en, i_Iss_num, i_Wen, i_Wnum, i_Wd,
        output o_Rd, o_Rbusy, o_Hazard, o_Iss_ready
    );
endinterface

// File: rtl/reg_file_scoreboard_rf_scoreboard.sv
// Pending-write busy bits: set on issue, cleared on writeback, looked up per read port.
module rf_scoreboard
    import reg_file_scoreboard_pkg::*;
#(
    parameter int NREGS  = RF_NREGS,
    parameter int NRD    = RF_NRD,
    parameter int BYPASS = RF_BYPASS,
    parameter int AW     = rf_aw(NREGS)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NRD*AW-1:0] i_rnum,
    input  logic              i_wen,
    input  logic [AW-1:0]     i_wnum,
    input  logic              i_iss_en,
    input  logic [AW-1:0]     i_iss_num,
    output logic [NRD-1:0]    o_rbusy,
    output logic              o_iss_ready
);
    logic [NREGS-1:0] r_busy;
    logic             w_wr_valid;
    logic             w_iss_fire;

    assign w_wr_valid  = i_wen && (i_wnum != '0);
    // A writeback retiring the same register this cycle frees it for a new producer.
    assign o_iss_ready = (i_iss_num == '0) || !r_busy[i_iss_num] ||
                         (i_wen && (i_wnum == i_iss_num));
    assign w_iss_fire  = i_iss_en && o_iss_ready && (i_iss_num != '0);

    // Issue is applied after the clear so the newer producer keeps the bit set.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= '0;
        end else begin
            if (w_wr_valid) r_busy[i_wnum] <= 1'b0;
            if (w_iss_fire) r_busy[i_iss_num] <= 1'b1;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rport
        logic [AW-1:0] w_rn;
        assign w_rn       = i_rnum[k*AW +: AW];
        assign o_rbusy[k] = (w_rn != '0) && r_busy[w_rn] &&
                            !((BYPASS != 0) && w_wr_valid && (i_wnum == w_rn));
    end
endmodule

// File: rtl/reg_file_scoreboard.sv
// NRD-read / 1-write integer register file with optional write bypass and scoreboard.
module reg_file_scoreboard
    import reg_file_scoreboard_pkg::*;
#(
    parameter int XLEN   = RF_XLEN,
    parameter int NREGS  = RF_NREGS,
    parameter int NRD    = RF_NRD,
    parameter int BYPASS = RF_BYPASS
) (
    input logic                  i_clk,
    input logic                  i_rst,
    reg_file_scoreboard_if.slave bus
);
    localparam int AW = rf_aw(NREGS);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wr_valid;
    logic [NRD-1:0]  w_rbusy;

    assign w_wr_valid = bus.i_Wen && (bus.i_Wnum != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_wr_valid) begin
            r_regs[bus.i_Wnum] <= bus.i_Wd;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rport
        logic [AW-1:0] w_rn;
        assign w_rn = bus.i_Rnum[k*AW +: AW];
        assign bus.o_Rd[k*XLEN +: XLEN] =
            (w_rn == '0) ? '0 :
            ((BYPASS != 0) && w_wr_valid && (bus.i_Wnum == w_rn)) ? bus.i_Wd :
            r_regs[w_rn];
    end

    rf_scoreboard #(
        .NREGS  (NREGS),
        .NRD    (NRD),
        .BYPASS (BYPASS),
        .AW     (AW)
    ) u_sb (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rnum      (bus.i_Rnum),
        .i_wen       (bus.i_Wen),
        .i_wnum      (bus.i_Wnum),
        .i_iss_en    (bus.i_Iss_en),
        .i_iss_num   (bus.i_Iss_num),
        .o_rbusy     (w_rbusy),
        .o_iss_ready (bus.o_Iss_ready)
    );

    assign bus.o_Rbusy  = w_rbusy;
    assign bus.o_Hazard = |w_rbusy;
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard (32x32, 2 read ports, bypass enabled).
module tb_reg_file_scoreboard;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    reg_file_scoreboard_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus ();

    reg_file_scoreboard #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.i_Rnum    = '0;
        bus.i_Iss_en  = 1'b0;
        bus.i_Iss_num = '0;
        bus.i_Wen     = 1'b0;
        bus.i_Wnum    = '0;
        bus.i_Wd      = '0;
    endtask

    // Commit one posedge, return at the following negedge with inputs idle.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            bus.i_Rnum    = {a[4:0], a[4:0]};
            bus.i_Iss_num = a[4:0];
            #1;
            n_vec++;
            if (bus.o_Rd !== 64'd0) begin
                n_err++;
                $display("FAIL reset_rd reg %0d: got %h expected 0", a, bus.o_Rd);
            end
            n_vec++;
            if (bus.o_Rbusy !== 2'b00 || bus.o_Hazard !== 1'b0) begin
                n_err++;
                $display("FAIL reset_busy reg %0d: got rbusy=%b hazard=%b expected 00/0", a, bus.o_Rbusy, bus.o_Hazard);
            end
            n_vec++;
            if (bus.o_Iss_ready !== 1'b1) begin
                n_err++;
                $display("FAIL reset_iss_ready reg %0d: got %b expected 1", a, bus.o_Iss_ready);
            end
        end
        tick();
    endtask

    task automatic test_write_read();
        bus.i_Wen = 1'b1; bus.i_Wnum = 5'd5; bus.i_Wd = 32'hDEADBEEF;
        tick();
        bus.i_Rnum = {5'd5, 5'd5};
        #1;
        n_vec++;
        if (bus.o_Rd !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL write_read_alias: got %h expected deadbeefdeadbeef", bus.o_Rd);
        end
        bus.i_Wen = 1'b1; bus.i_Wnum = 5'd0; bus.i_Wd = 32'h1;
        bus.i_Rnum = {5'd0, 5'd0};
        #1;
        n_vec++;
        if (bus.o_Rd !== 64'd0) begin
            n_err++;
            $display("FAIL write_r0_same_cycle: got %h expected 0", bus.o_Rd);
        end
        tick();
        bus.i_Rnum = {5'd5, 5'd0};
        #1;
        n_vec++;
        if (bus.o_Rd !== {32'hDEADBEEF, 32'h0}) begin
            n_err++;
            $display("FAIL write_r0_dropped: got %h expected deadbeef00000000", bus.o_Rd);
        end
    endtask

    task automatic test_bypass();
        bus.i_Wen = 1'b1; bus.i_Wnum = 5'd7; bus.i_Wd = 32'h1234;
        bus.i_Rnum = {5'd7, 5'd5};
        #1;
        n_vec++;
        if (bus.o_Rd !== {32'h1234, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL bypass_rd: got %h expected 00001234deadbeef", bus.o_Rd);
        end
        n_vec++;
        if (bus.o_Rbusy !== 2'b00) begin
            n_err++;
            $display("FAIL bypass_rbusy: got %b expected 00", bus.o_Rbusy);
        end
        tick();
        bus.i_Rnum = {5'd7, 5'd6};
        #1;
        n_vec++;
        if (bus.o_Rd !== {32'h1234, 32'h0}) begin
            n_err++;
            $display("FAIL bypass_stored: got %h expected 0000123400000000", bus.o_Rd);
        end
    endtask

    task automatic test_scoreboard();
        bus.i_Iss_en = 1'b1; bus.i_Iss_num = 5'd9;
        #1;
        n_vec++;
        if (bus.o_Iss_ready !== 1'b1) begin
            n_err++;
            $display("FAIL sb_first_issue_ready: got %b expected 1", bus.o_Iss_ready);
        end
        tick();
        bus.i_Rnum = {5'd0, 5'd9}; bus.i_Iss_num = 5'd9;
        #1;
        n_vec++;
        if (bus.o_Rbusy !== 2'b01 || bus.o_Hazard !== 1'b1) begin
            n_err++;
            $display("FAIL sb_busy: got rbusy=%b hazard=%b expected 01/1", bus.o_Rbusy, bus.o_Hazard);
        end
        n_vec++;
        if (bus.o_Iss_ready !== 1'b0) begin
            n_err++;
            $display("FAIL sb_waw_ready: got %b expected 0", bus.o_Iss_ready);
        end
        bus.i_Iss_num = 5'd10;
        #1;
        n_vec++;
        if (bus.o_Iss_ready !== 1'b1) begin
            n_err++;
            $display("FAIL sb_other_ready: got %b expected 1", bus.o_Iss_ready);
        end
        bus.i_Iss_en = 1'b1; bus.i_Iss_num = 5'd9;
        tick();
        bus.i_Rnum = {5'd10, 5'd9};
        #1;
        n_vec++;
        if (bus.o_Rbusy !== 2'b01) begin
            n_err++;
            $display("FAIL sb_reissue_ignored: got %b expected 01", bus.o_Rbusy);
        end
        bus.i_Wen = 1'b1; bus.i_Wnum = 5'd9; bus.i_Wd = 32'd55; bus.i_Iss_num = 5'd9;
        #1;
        n_vec++;
        if (bus.o_Rbusy !== 2'b00 || bus.o_Hazard !== 1'b0 || bus.o_Rd[31:0] !== 32'd55) begin
            n_err++;
            $display("FAIL sb_wb_bypass: got rbusy=%b hazard=%b rd0=%h expected 00/0/37", bus.o_Rbusy, bus.o_Hazard, bus.o_Rd[31:0]);
        end
        n_vec++;
        if (bus.o_Iss_ready !== 1'b1) begin
            n_err++;
            $display("FAIL sb_wb_frees_issue: got %b expected 1", bus.o_Iss_ready);
        end
        tick();
        bus.i_Rnum = {5'd0, 5'd9};
        #1;
        n_vec++;
        if (bus.o_Rbusy !== 2'b00 || bus.o_Rd[31:0] !== 32'd55) begin
            n_err++;
            $display("FAIL sb_after_wb: got rbusy=%b rd0=%h expected 00/37", bus.o_Rbusy, bus.o_Rd[31:0]);
        end
    endtask

    task automatic test_collision();
        bus.i_Iss_en = 1'b1; bus.i_Iss_num = 5'd3;
        tick();
        bus.i_Rnum = {5'd3, 5'd3};
        #1;
        n_vec++;
        if (bus.o_Rbusy !== 2'b11) begin
            n_err++;
            $display("FAIL coll_pre_busy: got %b expected 11", bus.o_Rbusy);
        end
        bus.i_Wen = 1'b1; bus.i_Wnum = 5'd3; bus.i_Wd = 32'd8;
        bus.i_Iss_en = 1'b1; bus.i_Iss_num = 5'd3;
        #1;
        n_vec++;
        if (bus.o_Iss_ready !== 1'b1) begin
            n_err++;
            $display("FAIL coll_ready: got %b expected 1", bus.o_Iss_ready);
        end
        tick();
        bus.i_Rnum = {5'd0, 5'd3};
        #1;
        n_vec++;
        if (bus.o_Rd[31:0] !== 32'd8 || bus.o_Rbusy !== 2'b01) begin
            n_err++;
            $display("FAIL coll_result: got rd0=%h rbusy=%b expected 8/01", bus.o_Rd[31:0], bus.o_Rbusy);
        end
    endtask

    task automatic test_reset_midop();
        bus.i_Iss_en = 1'b1; bus.i_Iss_num = 5'd4;
        tick();
        bus.i_Rnum = {5'd3, 5'd4};
        #1;
        n_vec++;
        if (bus.o_Rbusy !== 2'b11) begin
            n_err++;
            $display("FAIL midrst_pre_busy: got %b expected 11", bus.o_Rbusy);
        end
        rst = 1'b1;
        bus.i_Wen = 1'b1; bus.i_Wnum = 5'd4; bus.i_Wd = 32'd9;
        tick();
        rst = 1'b0;
        bus.i_Rnum = {5'd3, 5'd4}; bus.i_Iss_num = 5'd4;
        #1;
        n_vec++;
        if (bus.o_Rd !== 64'd0 || bus.o_Rbusy !== 2'b00 || bus.o_Hazard !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_state: got rd=%h rbusy=%b hazard=%b expected 0/00/0", bus.o_Rd, bus.o_Rbusy, bus.o_Hazard);
        end
        n_vec++;
        if (bus.o_Iss_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_ready: got %b expected 1", bus.o_Iss_ready);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        idle();
        @(negedge clk);
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_collision();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
